// File: rtl/insmem_fetch.sv
// Handshaked instruction memory for the fetch stage: one-cycle registered response,
// stall hold, flush drop. Define INSMEM_LOAD_EN to enable the runtime load port.
module insmem_fetch #(
    parameter int    ADDR_W      = 10,
    parameter int    DEPTH_WORDS = 256,
    parameter string INIT_FILE   = "",
    parameter int    CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_im_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_ins,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-3:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic [CNT_W-1:0]  fetch_cnt
);
    localparam int WI = ADDR_W - 2;
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // One extra bit so DEPTH_WORDS == 2**WI still compares correctly.
    localparam logic [WI:0] DEPTH_L = DEPTH_WORDS[WI:0];

    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic [31:0]       ins;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } rsp_t;

    state_t            state, state_n;
    rsp_t              rsp_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       mem [DEPTH_WORDS];
    logic [WI-1:0]     req_idx;
    logic              req_err;
    logic              accept;

    // Contents are not reset; they start as zero at elaboration.
    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
    end

    assign req_idx = req_addr[ADDR_W-1:2];
    assign req_err = (req_addr[1:0] != 2'b00) || ({1'b0, req_idx} >= DEPTH_L);

`ifdef INSMEM_LOAD_EN
    assign req_ready = rst_im_n && !ld_en && !flush && (!rsp_valid || rsp_ready);

    always_ff @(posedge clk) begin
        if (ld_en && ({1'b0, ld_addr} < DEPTH_L))
            mem[ld_addr[IW-1:0]] <= ld_data;
    end
`else
    logic unused_ld;
    assign unused_ld = ^{ld_en, ld_addr, ld_data};
    assign req_ready = rst_im_n && !flush && (!rsp_valid || rsp_ready);
`endif

    assign accept = req_valid && req_ready;

    always_comb begin
        state_n = state;
        case (state)
            EMPTY: if (accept) state_n = FULL;
            FULL: begin
                // Flush wins; accept is already masked by req_ready when flushing.
                if (flush) state_n = EMPTY;
                else if (rsp_ready && !accept) state_n = EMPTY;
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_im_n) begin
        if (!rst_im_n) begin
            state <= EMPTY;
            rsp_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                rsp_q.addr <= req_addr;
                rsp_q.err  <= req_err;
                rsp_q.ins  <= req_err ? 32'h0 : mem[req_idx[IW-1:0]];
                cnt_q      <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign rsp_valid = (state == FULL);
    assign rsp_ins   = rsp_q.ins;
    assign rsp_addr  = rsp_q.addr;
    assign rsp_err   = rsp_q.err;
    assign fetch_cnt = cnt_q;
endmodule

// File: tb/tb_insmem_fetch.sv
// Directed bench for insmem_fetch: sequential fetch, stall, errors, reset mid-stall,
// load port (INSMEM_LOAD_EN) and flush.
module tb_insmem_fetch;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 128;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_im_n;
    logic              req_valid, req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid, rsp_ready;
    logic [31:0]       rsp_ins;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_err;
    logic              flush;
    logic              ld_en;
    logic [ADDR_W-3:0] ld_addr;
    logic [31:0]       ld_data;
    logic [CNT_W-1:0]  fetch_cnt;

    int errs   = 0;
    int checks = 0;

    insmem_fetch #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .INIT_FILE(""), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_im_n(rst_im_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ins(rsp_ins),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err), .flush(flush),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_im_n  = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        // Program image: word k = A500_0000 | k.
        #1;
        for (int k = 0; k < DEPTH; k++) dut.mem[k] = 32'hA500_0000 | 32'(k);
        #10;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_ins",   rsp_ins,   0);
        chk("rst_addr",  rsp_addr,  0);
        chk("rst_err",   rsp_err,   0);
        chk("rst_cnt",   fetch_cnt, 0);
        chk("rst_ready", req_ready, 0);
        rst_im_n = 1'b1;
        tick();

        // Sequential fetch, back to back.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            req_addr = ADDR_W'(4 * k);
            tick();
            chk("seq_valid", rsp_valid, 1);
            chk("seq_ins",   rsp_ins,   32'hA500_0000 | 32'(k));
            chk("seq_addr",  rsp_addr,  4 * k);
            chk("seq_err",   rsp_err,   0);
        end
        chk("seq_cnt", fetch_cnt, 7);
        req_valid = 1'b0;
        tick();
        chk("seq_drain", rsp_valid, 0);

        // Stall: response held, next request blocked.
        req_valid = 1'b1;
        req_addr  = 'h10;
        tick();
        chk("stl_first", rsp_ins, 32'hA500_0004);
        rsp_ready = 1'b0;
        req_addr  = 'h14;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stl_ready", req_ready, 0);
            tick();
            chk("stl_valid", rsp_valid, 1);
            chk("stl_ins",   rsp_ins,   32'hA500_0004);
            chk("stl_addr",  rsp_addr,  'h10);
        end
        chk("stl_cnt", fetch_cnt, 8);
        rsp_ready = 1'b1;
        #1;
        chk("stl_rel_ready", req_ready, 1);
        tick();
        chk("stl_next_ins",  rsp_ins,  32'hA500_0005);
        chk("stl_next_addr", rsp_addr, 'h14);
        chk("stl_cnt2",      fetch_cnt, 9);
        req_valid = 1'b0;
        tick();

        // Error cases and last in-range word.
        req_valid = 1'b1;
        req_addr  = 'h002;
        tick();
        chk("err_mis",      rsp_err,  1);
        chk("err_mis_ins",  rsp_ins,  0);
        chk("err_mis_addr", rsp_addr, 'h002);
        req_addr = 'h1FC;
        tick();
        chk("err_last",     rsp_err, 0);
        chk("err_last_ins", rsp_ins, 32'hA500_007F);
        req_addr = 'h200;
        tick();
        chk("err_oor",      rsp_err,  1);
        chk("err_oor_ins",  rsp_ins,  0);
        chk("err_oor_addr", rsp_addr, 'h200);
        chk("err_cnt",      fetch_cnt, 12);
        req_valid = 1'b0;
        tick();

        // Reset while stalled.
        req_valid = 1'b1;
        req_addr  = 'h8;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        tick();
        chk("rms_held", rsp_valid, 1);
        rst_im_n = 1'b0;
        #1;
        chk("rms_valid", rsp_valid, 0);
        chk("rms_cnt",   fetch_cnt, 0);
        chk("rms_ins",   rsp_ins,   0);
        chk("rms_ready", req_ready, 0);
        tick();
        rst_im_n = 1'b1;
        tick();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 'h8;
        tick();
        chk("rms_refetch", rsp_ins,   32'hA500_0002);
        chk("rms_cnt1",    fetch_cnt, 1);
        req_valid = 1'b0;
        tick();

        // Load port write followed by fetch of the same word.
        ld_en     = 1'b1;
        ld_addr   = 3;
        ld_data   = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = 'hC;
`ifdef INSMEM_LOAD_EN
        #1;
        chk("ld_ready", req_ready, 0);
        tick();
        chk("ld_noacc", rsp_valid, 0);
        ld_en = 1'b0;
        tick();
        chk("ld_ins", rsp_ins, 32'hDEAD_BEEF);
`else
        #1;
        chk("ld_ready", req_ready, 1);
        tick();
        ld_en = 1'b0;
        chk("ld_ins", rsp_ins, 32'hA500_0003);
`endif
        chk("ld_cnt", fetch_cnt, 2);
        req_valid = 1'b0;
        tick();

        // Flush while FULL with a competing request.
        req_valid = 1'b1;
        req_addr  = 'h0;
        tick();
        chk("fl_full", rsp_valid, 1);
        flush    = 1'b1;
        req_addr = 'h4;
        #1;
        chk("fl_ready", req_ready, 0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("fl_valid", rsp_valid, 0);
        chk("fl_cnt",   fetch_cnt, 3);
        tick();
        chk("fl_empty", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
